// File: rtl/vga_fade_output.sv
// vga_fade_output: final pixel stage of the VGA path.
// Two-stage pipeline (input capture, then scale/blank/pack into uo_out) with a
// frame-synchronous brightness FSM: FADE_IN -> HOLD -> FADE_OUT -> DARK.
// Optional build macro: FADE_DITHER_EN replaces the constant rounding offset
// with a 2x2 ordered-dither offset.
module vga_fade_output #(
    parameter int STEP_FRAMES = 8,
    parameter int HOLD_FRAMES = 1800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [5:0] rgb_in,
    input  logic       wake,
    output logic [7:0] uo_out,
    output logic [2:0] level,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_FADE_IN  = 2'd0,
        ST_HOLD     = 2'd1,
        ST_FADE_OUT = 2'd2,
        ST_DARK     = 2'd3
    } state_e;

    localparam logic [7:0]  STEP_LAST = 8'(STEP_FRAMES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

    // Scale one 2-bit channel by level (0..4) with rounding offset d.
    // Product fits in 5 bits: 3*4+3 = 15, so the result never exceeds 3.
    function automatic logic [1:0] scale_chan(input logic [1:0] c,
                                              input logic [2:0] l,
                                              input logic [1:0] d);
        logic [4:0] p;
        p = ({3'b000, c} * {2'b00, l}) + {3'b000, d};
        return p[3:2];
    endfunction

    // Stage-1 pipeline registers
    logic [5:0]  rgb_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        de_q;
    logic        vsync_prev_q;

    // Fade state
    state_e      state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        wake_pend_q, wake_pend_d;

    // Stage-2 output register
    logic [7:0]  uo_q, uo_d;

    logic        tick_s;
    logic        wake_now_s;
    logic [1:0]  dith_s;

    // Falling edge of registered vsync marks the start of a new frame.
    assign tick_s     = vsync_prev_q & ~vsync_q;
    // A wake on the tick cycle itself is honoured at that tick.
    assign wake_now_s = wake_pend_q | wake;

`ifdef FADE_DITHER_EN
    logic px_q, px_d;
    logic ln_q, ln_d;

    // Pixel/line phase for the 2x2 Bayer pattern (0,2 / 3,1).
    always_comb begin
        px_d = 1'b0;
        ln_d = ln_q;
        if (de_q) begin
            px_d = ~px_q;
        end else begin
            px_d = 1'b0;
        end
        if (tick_s) begin
            ln_d = 1'b0;
        end else if (display_on && !de_q) begin
            ln_d = ~ln_q;
        end else begin
            ln_d = ln_q;
        end
    end

    // Dither phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            px_q <= 1'b0;
            ln_q <= 1'b0;
        end else begin
            px_q <= px_d;
            ln_q <= ln_d;
        end
    end

    assign dith_s = {px_q ^ ln_q, ln_q};
`else
    assign dith_s = 2'd2;
`endif

    // Next-state logic of the fade FSM; everything advances only on a frame tick.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        step_cnt_d  = step_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        wake_pend_d = wake_now_s;
        if (tick_s) begin
            // The pending wake is consumed (or ignored) by this tick.
            wake_pend_d = 1'b0;
            case (state_q)
                ST_FADE_IN: begin
                    if (level_q >= 3'd4) begin
                        // Entered from an early fade-out wake while still at full level.
                        level_d    = 3'd4;
                        state_d    = ST_HOLD;
                        hold_cnt_d = 16'd0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = 8'd0;
                        level_d    = level_q + 3'd1;
                        if (level_q == 3'd3) begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = 16'd0;
                        end else begin
                            state_d = ST_FADE_IN;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (wake_now_s) begin
                        hold_cnt_d = 16'd0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_FADE_OUT;
                        step_cnt_d = 8'd0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
                ST_FADE_OUT: begin
                    if (wake_now_s) begin
                        // Fade back in from wherever we are; level holds this tick.
                        state_d    = ST_FADE_IN;
                        step_cnt_d = 8'd0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = 8'd0;
                        if (level_q <= 3'd1) begin
                            level_d = 3'd0;
                            state_d = ST_DARK;
                        end else begin
                            level_d = level_q - 3'd1;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 8'd1;
                    end
                end
                ST_DARK: begin
                    level_d = 3'd0;
                    if (wake_now_s) begin
                        state_d    = ST_FADE_IN;
                        step_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_DARK;
                    end
                end
                default: begin
                    state_d    = ST_FADE_IN;
                    level_d    = 3'd0;
                    step_cnt_d = 8'd0;
                    hold_cnt_d = 16'd0;
                end
            endcase
        end else begin
            wake_pend_d = wake_now_s;
        end
    end

    // Scale, blank and pack the stage-1 pixel into the output byte.
    always_comb begin
        logic [1:0] r_s;
        logic [1:0] g_s;
        logic [1:0] b_s;
        r_s = 2'd0;
        g_s = 2'd0;
        b_s = 2'd0;
        if (de_q) begin
            r_s = scale_chan(rgb_q[5:4], level_q, dith_s);
            g_s = scale_chan(rgb_q[3:2], level_q, dith_s);
            b_s = scale_chan(rgb_q[1:0], level_q, dith_s);
        end else begin
            r_s = 2'd0;
            g_s = 2'd0;
            b_s = 2'd0;
        end
        uo_d = {hsync_q, b_s[0], g_s[0], r_s[0], vsync_q, b_s[1], g_s[1], r_s[1]};
    end

    // Pipeline, FSM and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q        <= 6'd0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            vsync_prev_q <= 1'b0;
            state_q      <= ST_FADE_IN;
            level_q      <= 3'd0;
            step_cnt_q   <= 8'd0;
            hold_cnt_q   <= 16'd0;
            wake_pend_q  <= 1'b0;
            uo_q         <= 8'h00;
        end else begin
            rgb_q        <= rgb_in;
            hsync_q      <= hsync_in;
            vsync_q      <= vsync_in;
            de_q         <= display_on;
            vsync_prev_q <= vsync_q;
            state_q      <= state_d;
            level_q      <= level_d;
            step_cnt_q   <= step_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            wake_pend_q  <= wake_pend_d;
            uo_q         <= uo_d;
        end
    end

    assign uo_out = uo_q;
    assign level  = level_q;
    assign state  = state_q;

endmodule

// File: tb/tb_vga_fade_output.sv
// Bench for vga_fade_output with STEP_FRAMES=2, HOLD_FRAMES=3 (default build).
module tb_vga_fade_output;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in;
    logic       vsync_in;
    logic       display_on;
    logic [5:0] rgb_in;
    logic       wake;
    logic [7:0] uo_out;
    logic [2:0] level;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] lvl;
        logic [5:0] rgb;
        logic       de;
        logic       hs;
        logic [5:0] exp_rgb;
    } pix_t;

    typedef struct {
        logic       vld;
        logic [7:0] v;
    } sb_t;

    pix_t tbl [0:12];
    sb_t  sb_q [$];

    vga_fade_output #(.STEP_FRAMES(2), .HOLD_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .display_on(display_on), .rgb_in(rgb_in), .wake(wake),
        .uo_out(uo_out), .level(level), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // {R1,R0,G1,G0,B1,B0} -> {hs,B0,G0,R0,vs,B1,G1,R1}
    function automatic logic [7:0] pack(input logic hs, input logic vs, input logic [5:0] c);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    task automatic chk_lv(input string name, input logic [2:0] el, input logic [1:0] es);
        chk({name, " level"}, {5'd0, level}, {5'd0, el});
        chk({name, " state"}, {6'd0, state}, {6'd0, es});
    endtask

    // One frame: vsync low for two cycles, optional wake on the tick cycle.
    task automatic frame_tick(input logic w);
        vsync_in = 1'b0;
        @(negedge clk);
        wake = w;
        @(negedge clk);
        wake = 1'b0;
        vsync_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick(1'b0);
    endtask

    task automatic wake_pulse();
        wake = 1'b1;
        @(negedge clk);
        wake = 1'b0;
        @(negedge clk);
    endtask

    task automatic sb_pop();
        sb_t e;
        if (sb_q.size() == 2) begin
            e = sb_q.pop_front();
            if (e.vld) chk("pixel", uo_out, e.v);
        end
    endtask

    // Stream table entries for one level; outputs are due exactly 2 cycles later.
    task automatic run_pixels(input logic [2:0] lvl);
        sb_q.delete();
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].lvl == lvl) begin
                @(negedge clk);
                sb_pop();
                rgb_in     = tbl[i].rgb;
                display_on = tbl[i].de;
                hsync_in   = tbl[i].hs;
                sb_q.push_back('{1'b1, pack(tbl[i].hs, 1'b1, tbl[i].exp_rgb)});
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sb_pop();
            rgb_in     = 6'd0;
            display_on = 1'b0;
            hsync_in   = 1'b0;
            sb_q.push_back('{1'b0, 8'h00});
        end
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{3'd4, 6'b111001, 1'b1, 1'b1, 6'b111001};
        tbl[1]  = '{3'd4, 6'b000000, 1'b1, 1'b0, 6'b000000};
        tbl[2]  = '{3'd4, 6'b111111, 1'b1, 1'b1, 6'b111111};
        tbl[3]  = '{3'd4, 6'b111001, 1'b0, 1'b0, 6'b000000};
        tbl[4]  = '{3'd2, 6'b111001, 1'b1, 1'b0, 6'b100101};
        tbl[5]  = '{3'd2, 6'b111111, 1'b1, 1'b1, 6'b101010};
        tbl[6]  = '{3'd2, 6'b010101, 1'b1, 1'b0, 6'b010101};
        tbl[7]  = '{3'd2, 6'b111001, 1'b0, 1'b1, 6'b000000};
        tbl[8]  = '{3'd1, 6'b111001, 1'b1, 1'b1, 6'b010100};
        tbl[9]  = '{3'd1, 6'b111111, 1'b1, 1'b0, 6'b010101};
        tbl[10] = '{3'd1, 6'b101010, 1'b1, 1'b1, 6'b010101};
        tbl[11] = '{3'd1, 6'b010101, 1'b1, 1'b0, 6'b000000};
        tbl[12] = '{3'd0, 6'b111111, 1'b1, 1'b1, 6'b000000};

        reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1; display_on = 1'b0;
        rgb_in = 6'd0; wake = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset uo", uo_out, 8'h00);
        chk_lv("reset", 3'd0, 2'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset uo", uo_out, 8'h00);
        @(negedge clk);
        chk_lv("no false tick", 3'd0, 2'd0);

        // Fade in: one level every 2 ticks, HOLD after 8.
        for (int t = 1; t <= 8; t++) begin
            frame_tick(1'b0);
            chk_lv("fade-in", 3'(t / 2), (t == 8) ? 2'd1 : 2'd0);
        end
        run_pixels(3'd4);

        // Hold expires on the 3rd tick.
        ticks(2);
        chk_lv("hold 2", 3'd4, 2'd1);
        frame_tick(1'b0);
        chk_lv("hold expire", 3'd4, 2'd2);

        // Fade out to DARK with pixel checks at levels 2 and 1.
        for (int t = 1; t <= 8; t++) begin
            frame_tick(1'b0);
            chk_lv("fade-out", 3'(4 - t / 2), (t == 8) ? 2'd3 : 2'd2);
            if (t == 4) run_pixels(3'd2);
            if (t == 6) run_pixels(3'd1);
        end
        for (int t = 0; t < 10; t++) begin
            frame_tick(1'b0);
            chk_lv("dark", 3'd0, 2'd3);
        end
        run_pixels(3'd0);

        // Wake on the tick cycle itself leaves DARK.
        frame_tick(1'b1);
        chk_lv("wake on tick", 3'd0, 2'd0);
        ticks(4);
        chk_lv("refade mid", 3'd2, 2'd0);
        ticks(4);
        chk_lv("refade full", 3'd4, 2'd1);

        // Wake in HOLD after 2 ticks restarts the hold count.
        ticks(2);
        wake_pulse();
        frame_tick(1'b0);
        chk_lv("hold wake", 3'd4, 2'd1);
        ticks(2);
        chk_lv("hold restarted", 3'd4, 2'd1);
        frame_tick(1'b0);
        chk_lv("hold late expire", 3'd4, 2'd2);

        // Wake in FADE_OUT at level 2.
        ticks(4);
        chk_lv("fo level2", 3'd2, 2'd2);
        wake_pulse();
        frame_tick(1'b0);
        chk_lv("fo wake", 3'd2, 2'd0);
        frame_tick(1'b0);
        chk_lv("fo wake +1", 3'd2, 2'd0);
        frame_tick(1'b0);
        chk_lv("fo wake +2", 3'd3, 2'd0);

        // Back to FADE_OUT at level 3, then reset mid-fade.
        ticks(2);
        chk_lv("back hold", 3'd4, 2'd1);
        ticks(3);
        ticks(2);
        chk_lv("fo level3", 3'd3, 2'd2);
        display_on = 1'b1; rgb_in = 6'b111111; hsync_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_lv("mid reset", 3'd0, 2'd0);
        chk("mid reset uo", uo_out, 8'h00);
        reset = 1'b0;
        display_on = 1'b0; rgb_in = 6'd0; hsync_in = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fade_output.md
# vga_fade_output

Final pixel stage of the Sleepwell VGA path. It consumes the 6-bit colour and the sync and display-enable signals from the scene renderer, and scales the colour by a frame-synchronous brightness level. The level is driven by a fade-in / hold / fade-out / dark state machine. The block registers and packs everything into the TinyTapeout `uo_out` byte with equal latency on colour and sync.

## Interface
- `STEP_FRAMES`, default 8: frame ticks per brightness step; legal range 1..255.
- `HOLD_FRAMES`, default 1800: frame ticks held at full brightness before fade-out; legal range 1..65535.
- `clk` input 1: pixel clock.
- `reset` input 1: synchronous, active-high reset.
- `hsync_in` input 1: horizontal sync from the sync generator, passed through unmodified in polarity.
- `vsync_in` input 1: vertical sync, active-low.
- `display_on` input 1: high in the visible area.
- `rgb_in` input 6: {R[1:0], G[1:0], B[1:0]} from the renderer.
- `wake` input 1: single-cycle or level request to restart the fade-in.
- `uo_out` output 8: {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}.
- `level` output 3: current brightness, 0..4.
- `state` output 2: 0=FADE_IN, 1=HOLD, 2=FADE_OUT, 3=DARK.

## Operation
- **Frame tick**
  - A one-cycle pulse generated on the falling edge of `vsync_in`.
  - Detected from the stage-1 registered vsync against its previous value.
  - All state, level and counter updates happen only on a frame tick.
- **Wake latch**
  - `wake` high on any cycle sets `wake_pend`.
  - `wake_pend` is cleared on the next frame tick, after it has been consumed.
- **FADE_IN**
  - `step_cnt` increments per tick.
  - When `step_cnt == STEP_FRAMES-1`: `step_cnt` is cleared and `level` increments.
  - When `level` becomes 4: go to HOLD and clear `hold_cnt`.
  - Wake is ignored.
- **HOLD**
  - `hold_cnt` increments per tick. When `hold_cnt == HOLD_FRAMES-1`: go to FADE_OUT and clear `step_cnt`.
  - `wake_pend` at a tick clears `hold_cnt` and stays in HOLD. Wake has priority over expiry.
- **FADE_OUT**
  - Steps as FADE_IN, but `level` decrements. At `level` 0, go to DARK.
  - `wake_pend` at a tick goes to FADE_IN from the current level, clears `step_cnt`, and the level does not change that tick.
- **DARK**
  - `level` stays 0.
  - `wake_pend` at a tick goes to FADE_IN and clears `step_cnt`.
- **Scaling**
  - Per channel c (2 bits): out = (c*L + 2) >> 2, where L = `level`.
  - The product is 5 bits wide; no saturation is needed, since the maximum is (3*4+2)>>2 = 3.
  - L=4 is identity; L=0 gives black.
- **Blanking**
  - If the stage-1 `display_on` is low, all six colour bits are 0, regardless of level.

## Timing
- **Pipeline**
  - Stage 1 registers `rgb_in`, `hsync_in`, `vsync_in` and `display_on`.
  - Stage 2 registers the scaled and packed `uo_out`.
  - Latency is exactly 2 clocks for colour, hsync and vsync alike; sync-to-pixel alignment is preserved.
- **State outputs**
  - `level` and `state` update one clock after the frame tick.
  - The tick falls inside vertical blanking, so brightness never changes mid-frame.
- **Reset values**
  - `uo_out` = 8'h00.
  - `level` = 0, `state` = FADE_IN.
  - `step_cnt`, `hold_cnt`, `wake_pend`, all pipeline registers and the previous-vsync register are 0.
  - Because the previous-vsync register starts at 0, no false tick is generated on the first cycle after reset when vsync is high.
- **Reset mid-fade** returns immediately to the reset values and restarts the fade-in from level 0.
- **Simultaneous `wake` and tick on the same cycle:** the wake takes effect at that tick.

## Configuration
- **`FADE_DITHER_EN` defined**
  - The rounding constant 2 is replaced by the 2x2 Bayer value d = 2*(px^ln) + ln, giving patterns 0,2 / 3,1.
  - px toggles every cycle that stage-1 `display_on` is high, and clears when it is low.
  - ln toggles on each rising edge of `display_on`, and clears on a frame tick.
  - px and ln reset to 0.
  - Intermediate levels then show spatial dithering instead of flat rounding.
- **Undefined:** the constant rounding offset of 2; the px/ln logic is not built.

## Test plan
All scenarios use STEP_FRAMES=2 and HOLD_FRAMES=3.
- **Reset:** release `reset` -> `uo_out`=00, `level`=0, `state`=0. After 2 ticks `level`=1; after 8 ticks `level`=4 and `state`=1.
- **Hold:** at `level` 4, the 3rd tick in HOLD moves to FADE_OUT. 8 further ticks bring `level` to 0 and `state` to 3; DARK then persists for 10 ticks.
- **Scaling**, `rgb_in`=6'b11_10_01 with `display_on`=1:
  - L=4 -> `uo_out` colour bits equal the input.
  - L=2 -> R=2, G=1, B=1.
  - L=1 -> R=1, G=1, B=0.
  - `display_on`=0 -> all colour bits 0.
- **Latency:** toggle `hsync_in` at cycle N -> `uo_out`[7] toggles at N+2. Colour changes at cycle N -> visible at N+2.
- **Wake:**
  - A wake pulse in HOLD after 2 ticks -> `hold_cnt` restarts, and fade-out begins only 3 ticks later.
  - A wake in FADE_OUT at `level` 2 -> FADE_IN, and `level` reaches 3 after 2 more ticks.
- **Reset mid-operation:** assert `reset` during FADE_OUT at `level` 3 -> the next cycle shows `level`=0, `state`=0 and `uo_out`=00.
